// File: rtl/spi_txn_controller_if.sv
// Handshake bundle between the SPI transaction controller, its host, FIFOs and SPI master.
// The master modport is the controller's view; slave is the surrounding environment.
interface spi_txn_controller_if;
    logic        start;
    logic [15:0] byte_count;
    logic        read_en;
    logic        keep_cs;
    logic        abort;
    logic        txf_nempty;
    logic [7:0]  txf_data;
    logic        txf_pop;
    logic        spi_go;
    logic        spi_busy;
    logic [7:0]  spi_din;
    logic [7:0]  spi_dout;
    logic        rxf_full;
    logic        rxf_push;
    logic [7:0]  rxf_data;
    logic        cs_active;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] bytes_done;

    modport master (
        input  start, byte_count, read_en, keep_cs, abort,
        input  txf_nempty, txf_data, spi_busy, spi_dout, rxf_full,
        output txf_pop, spi_go, spi_din, rxf_push, rxf_data,
        output cs_active, busy, done, aborted, bytes_done
    );

    modport slave (
        output start, byte_count, read_en, keep_cs, abort,
        output txf_nempty, txf_data, spi_busy, spi_dout, rxf_full,
        input  txf_pop, spi_go, spi_din, rxf_push, rxf_data,
        input  cs_active, busy, done, aborted, bytes_done
    );
endinterface

// File: rtl/spi_txn_controller.sv
// Sequences a multi-byte SPI transaction: CS setup, per-byte TX pop / SPI go / RX push,
// CS hold, with abort and keep-CS support. All outputs are registered.
module spi_txn_controller #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic clock,
    input  logic reset,
    spi_txn_controller_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, SETUP, LOAD, GO, WAIT_START, WAIT_END, STORE, HOLD, FINISH
    } state_t;

    // Each counted state always occupies at least one cycle, so a zero count behaves like one.
    localparam logic [15:0] SETUP_LAST = 16'((CS_SETUP > 1) ? CS_SETUP - 1 : 0);
    localparam logic [15:0] HOLD_LAST  = 16'((CS_HOLD  > 1) ? CS_HOLD  - 1 : 0);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] count_q;
    logic        read_q;
    logic        keep_q;
    logic        abort_q;
    logic        txf_pop_q;
    logic        spi_go_q;
    logic [7:0]  spi_din_q;
    logic        rxf_push_q;
    logic [7:0]  rxf_data_q;
    logic        cs_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;
    logic [15:0] bytes_done_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            count_q      <= '0;
            read_q       <= 1'b0;
            keep_q       <= 1'b0;
            abort_q      <= 1'b0;
            txf_pop_q    <= 1'b0;
            spi_go_q     <= 1'b0;
            spi_din_q    <= '0;
            rxf_push_q   <= 1'b0;
            rxf_data_q   <= '0;
            cs_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            bytes_done_q <= '0;
        end else begin
            txf_pop_q  <= 1'b0;
            spi_go_q   <= 1'b0;
            rxf_push_q <= 1'b0;
            done_q     <= 1'b0;
            // Once a byte is in flight, an abort is remembered and honoured after it lands.
            if (bus.abort && (state inside {GO, WAIT_START, WAIT_END, STORE}))
                abort_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bytes_done_q <= '0;
                        aborted_q    <= 1'b0;
                        abort_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        if (bus.byte_count != 16'd0) begin
                            count_q <= bus.byte_count;
                            read_q  <= bus.read_en;
                            keep_q  <= bus.keep_cs;
                            cs_q    <= 1'b1;
                            cnt     <= '0;
                            state   <= SETUP;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                SETUP: begin
                    if (bus.abort) begin
                        abort_q <= 1'b1;
                        cnt     <= '0;
                        state   <= HOLD;
                    end else if (cnt >= SETUP_LAST) begin
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        abort_q <= 1'b1;
                        cnt     <= '0;
                        state   <= HOLD;
                    end else if (bus.txf_nempty) begin
                        spi_din_q <= bus.txf_data;
                        txf_pop_q <= 1'b1;
                        spi_go_q  <= 1'b1;
                        state     <= GO;
                    end
                end
                GO:         state <= WAIT_START;
                WAIT_START: if (bus.spi_busy) state <= WAIT_END;
                WAIT_END: begin
                    if (!bus.spi_busy) begin
                        rxf_data_q <= bus.spi_dout;
                        state      <= STORE;
                    end
                end
                STORE: begin
                    if (!read_q || !bus.rxf_full) begin
                        rxf_push_q   <= read_q;
                        bytes_done_q <= bytes_done_q + 16'd1;
                        cnt          <= '0;
                        if (abort_q || bus.abort || (bytes_done_q + 16'd1 == count_q))
                            state <= HOLD;
                        else
                            state <= LOAD;
                    end
                end
                HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        if (!keep_q || abort_q)
                            cs_q <= 1'b0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FINISH: begin
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    aborted_q <= abort_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txf_pop    = txf_pop_q;
    assign bus.spi_go     = spi_go_q;
    assign bus.spi_din    = spi_din_q;
    assign bus.rxf_push   = rxf_push_q;
    assign bus.rxf_data   = rxf_data_q;
    assign bus.cs_active  = cs_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.bytes_done = bytes_done_q;
endmodule

// File: tb/tb_spi_txn_controller.sv
// Bench for spi_txn_controller: TX FIFO and loop-back SPI models, RX scoreboard queue,
// a table of whole transactions, then hand-written stall / full / abort / reset sequences.
module tb_spi_txn_controller;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_txn_controller_if bus ();

    spi_txn_controller #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0, pops = 0, gos = 0, pushes = 0, dones = 0, cs_cycles = 0;
    int done_cyc = 0, last_push_cyc = 0, cs_fall_cyc = 0, start_cyc = 0;
    int spi_left;
    logic [7:0] spi_shift;
    logic cs_prev = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] exp_rx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SPI master: busy for 3 cycles after go, returns the byte it was given. Also pops the TX model.
    always @(posedge clock) begin
        if (!reset) begin
            bus.spi_busy <= 1'b0;
            bus.spi_dout <= 8'h00;
            spi_left     <= 0;
        end else if (bus.spi_go) begin
            bus.spi_busy <= 1'b1;
            spi_shift    <= bus.spi_din;
            spi_left     <= 3;
        end else if (spi_left > 0) begin
            spi_left <= spi_left - 1;
            if (spi_left == 1) begin
                bus.spi_busy <= 1'b0;
                bus.spi_dout <= spi_shift;
            end
        end
        if (reset && bus.txf_pop) begin
            if (txq.size() == 0) chk("txf_pop_on_empty", 1, 0);
            else void'(txq.pop_front());
        end
    end

    // Output monitor and RX scoreboard; also presents the TX FIFO head away from the clock edge.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (bus.txf_pop) pops++;
            if (bus.spi_go) gos++;
            if (bus.done) begin dones++; done_cyc = cyc; end
            if (bus.cs_active) cs_cycles++;
            if (cs_prev && !bus.cs_active) cs_fall_cyc = cyc;
            if (bus.rxf_push) begin
                pushes++;
                last_push_cyc = cyc;
                if (exp_rx.size() == 0) chk("rx_unexpected_push", 1, 0);
                else chk("rx_data", {24'h0, bus.rxf_data}, {24'h0, exp_rx.pop_front()});
            end
        end
        cs_prev = bus.cs_active;
        bus.txf_nempty = (txq.size() != 0);
        bus.txf_data   = (txq.size() != 0) ? txq[0] : 8'h00;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_txn(input logic [15:0] bc, input bit rd, input bit keep);
        bus.byte_count = bc;
        bus.read_en    = rd;
        bus.keep_cs    = keep;
        bus.start      = 1'b1;
        start_cyc      = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int n = 0;
        while (dones == d0 && n < 1000) begin tick(); n++; end
        chk({name, "_done_seen"}, (dones != d0), 1);
    endtask

    task automatic wait_pushes(input int target);
        int n = 0;
        while (pushes < target && n < 1000) begin tick(); n++; end
        chk("push_wait", (pushes >= target), 1);
    endtask

    task automatic wait_go_busy(input int target);
        int n = 0;
        while (!(gos >= target && bus.spi_busy) && n < 1000) begin tick(); n++; end
        chk("go_busy_wait", (gos >= target && bus.spi_busy), 1);
    endtask

    task automatic wait_spi_idle();
        int n = 0;
        while (bus.spi_busy && n < 1000) begin tick(); n++; end
        chk("spi_idle_wait", bus.spi_busy, 0);
    endtask

    typedef struct {
        logic [15:0]     bc;
        bit              rd;
        bit              keep;
        logic [3:0][7:0] data;
        int              exp_pops;
        int              exp_push;
        logic [15:0]     exp_bd;
        bit              exp_cs;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, g0, q0, d0, c0;
        bus.start = 1'b0; bus.byte_count = 16'd0; bus.read_en = 1'b0; bus.keep_cs = 1'b0;
        bus.abort = 1'b0; bus.rxf_full = 1'b0;

        vecs[0] = '{16'd3, 1'b1, 1'b0, 32'h00FF3CA5, 3, 3, 16'd3, 1'b0};
        vecs[1] = '{16'd0, 1'b1, 1'b0, 32'h0,        0, 0, 16'd0, 1'b0};
        vecs[2] = '{16'd1, 1'b0, 1'b0, 32'h0,        1, 0, 16'd1, 1'b0};
        vecs[3] = '{16'd4, 1'b1, 1'b0, 32'h0,        4, 4, 16'd4, 1'b0};
        vecs[4] = '{16'd2, 1'b1, 1'b1, 32'h0,        2, 2, 16'd2, 1'b1};
        for (int i = 2; i < 5; i++) vecs[i].data = $urandom;

        repeat (3) tick();
        chk("reset_ctrl", {bus.cs_active, bus.txf_pop, bus.spi_go, bus.rxf_push,
                           bus.busy, bus.done, bus.aborted}, 0);
        chk("reset_data", {bus.spi_din, bus.rxf_data, bus.bytes_done}, 0);
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            p0 = pops; g0 = gos; q0 = pushes; d0 = dones; c0 = cs_cycles;
            for (int b = 0; b < int'(vecs[i].bc); b++) begin
                txq.push_back(vecs[i].data[b]);
                if (vecs[i].rd) exp_rx.push_back(vecs[i].data[b]);
            end
            start_txn(vecs[i].bc, vecs[i].rd, vecs[i].keep);
            wait_done($sformatf("vec%0d", i), d0);
            tick();
            chk($sformatf("vec%0d_pops", i), pops - p0, vecs[i].exp_pops);
            chk($sformatf("vec%0d_gos", i), gos - g0, vecs[i].exp_pops);
            chk($sformatf("vec%0d_pushes", i), pushes - q0, vecs[i].exp_push);
            chk($sformatf("vec%0d_bytes_done", i), bus.bytes_done, vecs[i].exp_bd);
            chk($sformatf("vec%0d_cs", i), bus.cs_active, vecs[i].exp_cs);
            chk($sformatf("vec%0d_flags", i), {bus.busy, bus.aborted}, 0);
            chk($sformatf("vec%0d_rx_left", i), exp_rx.size(), 0);
            if (i == 0) chk("cs_hold_cycles", cs_fall_cyc - last_push_cyc, CS_HOLD);
            if (vecs[i].bc == 16'd0) begin
                chk("zero_done_latency", done_cyc - start_cyc, 2);
                chk("zero_cs_untouched", cs_cycles - c0, 0);
            end
        end

        // TX FIFO runs dry after the first byte; a stray start mid-transfer must be ignored.
        p0 = pops; q0 = pushes; d0 = dones;
        txq.push_back(8'h11);
        exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33);
        start_txn(16'd3, 1'b1, 1'b0);
        wait_pushes(q0 + 1);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                bus.byte_count = 16'd1; bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end else begin
                tick();
            end
        end
        chk("stall_pops", pops - p0, 1);
        chk("stall_cs_busy", {bus.cs_active, bus.busy}, 2'b11);
        txq.push_back(8'h22); txq.push_back(8'h33);
        wait_done("stall", d0);
        tick();
        chk("stall_total_pops", pops - p0, 3);
        chk("stall_total_pushes", pushes - q0, 3);
        chk("stall_bytes_done", bus.bytes_done, 3);

        // RX FIFO full while the byte waits in STORE.
        g0 = gos; q0 = pushes; d0 = dones;
        bus.rxf_full = 1'b1;
        txq.push_back(8'h5A); exp_rx.push_back(8'h5A);
        start_txn(16'd1, 1'b1, 1'b0);
        wait_go_busy(g0 + 1);
        wait_spi_idle();
        repeat (5) tick();
        chk("full_no_push", pushes - q0, 0);
        chk("full_still_busy", bus.busy, 1);
        bus.rxf_full = 1'b0;
        wait_done("full", d0);
        tick();
        chk("full_one_push", pushes - q0, 1);

        // Abort during byte 2 of 4: byte 2 still lands, CS released, aborted sticky.
        p0 = pops; g0 = gos; q0 = pushes; d0 = dones;
        txq.push_back(8'hC1); txq.push_back(8'hC2); txq.push_back(8'hC3); txq.push_back(8'hC4);
        exp_rx.push_back(8'hC1); exp_rx.push_back(8'hC2);
        start_txn(16'd4, 1'b1, 1'b0);
        wait_go_busy(g0 + 2);
        tick();
        bus.abort = 1'b1;
        wait_done("abort", d0);
        bus.abort = 1'b0;
        tick();
        chk("abort_bytes_done", bus.bytes_done, 2);
        chk("abort_pushes", pushes - q0, 2);
        chk("abort_pops", pops - p0, 2);
        chk("abort_cs_aborted", {bus.cs_active, bus.aborted}, 2'b01);
        chk("abort_one_done", dones - d0, 1);
        txq.delete();

        // keep_cs holds CS across transactions; reset mid-transfer clears everything.
        d0 = dones;
        txq.push_back(8'h77); exp_rx.push_back(8'h77);
        start_txn(16'd1, 1'b1, 1'b1);
        wait_done("keep", d0);
        tick();
        chk("keep_aborted_cleared", bus.aborted, 0);
        repeat (3) tick();
        chk("keep_cs_held", bus.cs_active, 1);
        g0 = gos;
        txq.push_back(8'h88); txq.push_back(8'h99);
        exp_rx.push_back(8'h88); exp_rx.push_back(8'h99);
        start_txn(16'd2, 1'b1, 1'b0);
        chk("keep_cs_second", bus.cs_active, 1);
        wait_go_busy(g0 + 1);
        reset = 1'b0;
        tick();
        chk("midreset_ctrl", {bus.cs_active, bus.txf_pop, bus.spi_go, bus.rxf_push,
                              bus.busy, bus.done, bus.aborted}, 0);
        chk("midreset_data", {bus.spi_din, bus.rxf_data, bus.bytes_done}, 0);
        txq.delete();
        exp_rx.delete();
        tick();
        reset = 1'b1;
        p0 = pops; q0 = pushes;
        repeat (5) tick();
        chk("post_reset_quiet", {pops - p0, pushes - q0}, 0);
        chk("post_reset_idle", {bus.busy, bus.cs_active}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_txn_controller.md
SPI_TXN_CONTROLLER -- requirements
Module: spi_txn_controller

Interface
REQ-001 Parameter CS_SETUP, default 2: clock cycles between CS assertion and first spi_go.
REQ-002 Parameter CS_HOLD, default 2: clock cycles between last byte completion and CS release.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a transaction; sampled only in IDLE.
REQ-006 byte_count  in  16  bytes to transfer; latched on accepted start.
REQ-007 read_en  in  1  1 = push received bytes to RX FIFO; latched on accepted start.
REQ-008 keep_cs  in  1  1 = leave CS asserted at end (multi-part transfer); latched on accepted start.
REQ-009 abort  in  1  request early termination; level, sampled every cycle.
REQ-010 txf_nempty  in  1  TX FIFO has data; txf_data valid.
REQ-011 txf_data  in  8  TX FIFO head byte.
REQ-012 txf_pop  out  1  one-cycle pop of TX FIFO head.
REQ-013 spi_go  out  1  one-cycle start pulse to SPI master.
REQ-014 spi_busy  in  1  SPI master state (1 = transmitting).
REQ-015 spi_din  out  8  byte to SPI master; registered.
REQ-016 spi_dout  in  8  byte received by SPI master.
REQ-017 rxf_full  in  1  RX FIFO full.
REQ-018 rxf_push  out  1  one-cycle push into RX FIFO.
REQ-019 rxf_data  out  8  byte to RX FIFO; registered.
REQ-020 cs_active  out  1  CS request to pin logic (1 = asserted; polarity applied downstream).
REQ-021 busy  out  1  1 whenever state != IDLE.
REQ-022 done  out  1  one-cycle pulse at transaction end.
REQ-023 aborted  out  1  sticky; set when a transaction ends by abort; cleared on next accepted start.
REQ-024 bytes_done  out  16  bytes completed in current/last transaction.

Function
REQ-025 States SHALL be IDLE, SETUP, LOAD, GO, WAIT_START, WAIT_END, STORE, HOLD, FINISH.
REQ-026 IDLE: start=1 with byte_count!=0 SHALL latch config, clear bytes_done/aborted, assert cs_active (unless already asserted from keep_cs), enter SETUP next cycle.
REQ-027 IDLE: start=1 with byte_count==0 SHALL go directly to FINISH, touching neither CS nor FIFOs.
REQ-028 SETUP SHALL count CS_SETUP cycles then enter LOAD; CS_SETUP=0 enters LOAD next cycle.
REQ-029 LOAD: txf_nempty=1 SHALL register txf_data into spi_din, pulse txf_pop, enter GO; txf_nempty=0 stalls in LOAD (no pop, CS held).
REQ-030 GO SHALL pulse spi_go for exactly one cycle and enter WAIT_START.
REQ-031 WAIT_START SHALL wait for spi_busy=1, then WAIT_END SHALL wait for spi_busy=0 and register spi_dout into rxf_data.
REQ-032 STORE: read_en=0 SHALL skip the push; read_en=1 and rxf_full=0 SHALL pulse rxf_push once; rxf_full=1 stalls (no push, no byte loss).
REQ-033 On leaving STORE, bytes_done SHALL increment by 1; bytes_done==byte_count enters HOLD, otherwise LOAD.
REQ-034 HOLD SHALL count CS_HOLD cycles, then deassert cs_active unless keep_cs=1, then enter FINISH.
REQ-035 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-036 abort=1 in SETUP or LOAD SHALL enter HOLD next cycle with no pop/go; in GO/WAIT_START/WAIT_END/STORE the current byte SHALL complete (incl. push) before HOLD; aborted set at FINISH.
REQ-037 Abort SHALL always release CS regardless of keep_cs.
REQ-038 start outside IDLE SHALL be ignored.
REQ-039 Minimum per-byte overhead from LOAD entry to rxf_push: LOAD 1, GO 1, WAIT_START >=1, WAIT_END (SPI time), STORE 1.

Reset
REQ-040 reset=0 at a clock edge SHALL force IDLE; cs_active, txf_pop, spi_go, rxf_push, busy, done, aborted = 0; spi_din, rxf_data, bytes_done = 0; applies mid-transaction with no further pops/pushes.

Verification
REQ-041 start, byte_count=3, read_en=1, TX FIFO holds A5,3C,FF, SPI loops back -> 3 pops, 3 go, RX gets A5,3C,FF, bytes_done=3, cs_active low CS_HOLD cycles after 3rd byte, one done.
REQ-042 byte_count=0 -> done 2 cycles after start, cs_active never 1, no pop/go/push.
REQ-043 TX FIFO empty for 10 cycles mid-transfer, then byte arrives -> controller stalls in LOAD with CS held, resumes, correct count.
REQ-044 rxf_full=1 held 5 cycles at STORE -> no push while full, single push after release, data unchanged.
REQ-045 abort asserted during WAIT_END of byte 2 of 4 -> byte 2 completes and is pushed, bytes_done=2, CS released, aborted=1, done pulsed.
REQ-046 keep_cs=1 transaction of 1 byte, then reset=0 mid-second transaction -> cs_active stays 1 between transactions, drops to 0 on the reset edge, all outputs at reset values.
